// File: rtl/reg_exchange_responder.sv
// Register-exchange responder: holds registers A and B and executes READ, LOAD_A, LOAD_B and SWAP
// commands over a valid/ready request channel, returning post-operation values on a response channel.
module reg_exchange_responder #(
   parameter int               WIDTH  = 8,
   parameter logic [WIDTH-1:0] A_INIT = WIDTH'(5),
   parameter logic [WIDTH-1:0] B_INIT = WIDTH'(10)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [1:0]       req_op,
   input  logic [WIDTH-1:0] req_data,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_a,
   output logic [WIDTH-1:0] rsp_b,
   output logic [WIDTH-1:0] reg_a,
   output logic [WIDTH-1:0] reg_b,
   output logic [7:0]       swap_count
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      OP_READ   = 2'b00,
      OP_LOAD_A = 2'b01,
      OP_LOAD_B = 2'b10,
      OP_SWAP   = 2'b11
   } op_t;

   state_t           state;
   op_t              op_q;
   logic [WIDTH-1:0] data_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         req_ready  <= 1'b1;
         rsp_valid  <= 1'b0;
         rsp_a      <= '0;
         rsp_b      <= '0;
         reg_a      <= A_INIT;
         reg_b      <= B_INIT;
         swap_count <= 8'd0;
         // NOTE: op_q/data_q are always written on acceptance before they are read, so they need no reset.
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  op_q      <= op_t'(req_op);
                  data_q    <= req_data;
                  req_ready <= 1'b0;
                  state     <= EXEC;
               end
            end

            EXEC: begin
               rsp_valid <= 1'b1;
               state     <= RESP;
               case (op_q)
                  OP_LOAD_A: begin
                     reg_a <= data_q;
                     rsp_a <= data_q;
                     rsp_b <= reg_b;
                  end
                  OP_LOAD_B: begin
                     reg_b <= data_q;
                     rsp_a <= reg_a;
                     rsp_b <= data_q;
                  end
                  OP_SWAP: begin
                     // NOTE: non-blocking assignments read pre-edge values, so this is a true exchange.
                     reg_a      <= reg_b;
                     reg_b      <= reg_a;
                     rsp_a      <= reg_b;
                     rsp_b      <= reg_a;
                     swap_count <= swap_count + 8'd1;
                  end
                  default: begin
                     rsp_a <= reg_a;
                     rsp_b <= reg_b;
                  end
               endcase
            end

            RESP: begin
               // Response values stay frozen until the initiator takes them.
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  req_ready <= 1'b1;
                  state     <= IDLE;
               end
            end

            default: begin
               rsp_valid <= 1'b0;
               req_ready <= 1'b1;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_reg_exchange_responder.sv
// Self-checking bench for reg_exchange_responder: transaction-level reference model compared every
// cycle, directed test-plan scenarios with literal expectations, then randomized command traffic.
module tb_reg_exchange_responder;

   localparam int         WIDTH  = 8;
   localparam logic [7:0] A_INIT = 8'd5;
   localparam logic [7:0] B_INIT = 8'd10;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             req_valid = 1'b0;
   logic             req_ready;
   logic [1:0]       req_op = 2'b00;
   logic [WIDTH-1:0] req_data = '0;
   logic             rsp_valid;
   logic             rsp_ready = 1'b0;
   logic [WIDTH-1:0] rsp_a, rsp_b, reg_a, reg_b;
   logic [7:0]       swap_count;

   int checks = 0;
   int errors = 0;

   reg_exchange_responder #(.WIDTH(WIDTH), .A_INIT(A_INIT), .B_INIT(B_INIT)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op     (req_op),
      .req_data   (req_data),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_a      (rsp_a),
      .rsp_b      (rsp_b),
      .reg_a      (reg_a),
      .reg_b      (reg_b),
      .swap_count (swap_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model (transaction level) ----------------
   // A transaction is "pending" for one cycle after acceptance, then "responding" until rsp_ready.
   int         m_a, m_b, m_swaps;
   int         m_ra, m_rb;
   bit         m_pend, m_resp;
   logic [1:0] m_op;
   int         m_d;
   bit         run_cmp = 1'b0;

   always @(posedge clk) begin : model
      if (!rst_n) begin
         m_a     <= A_INIT;
         m_b     <= B_INIT;
         m_swaps <= 0;
         m_pend  <= 1'b0;
         m_resp  <= 1'b0;
      end else if (m_resp) begin
         if (rsp_ready) m_resp <= 1'b0;
      end else if (m_pend) begin
         m_pend <= 1'b0;
         m_resp <= 1'b1;
         case (m_op)
            2'b01:   begin m_a <= m_d; m_ra <= m_d; m_rb <= m_b; end
            2'b10:   begin m_b <= m_d; m_ra <= m_a; m_rb <= m_d; end
            2'b11:   begin m_a <= m_b; m_b <= m_a; m_ra <= m_b; m_rb <= m_a; m_swaps <= m_swaps + 1; end
            default: begin m_ra <= m_a; m_rb <= m_b; end
         endcase
      end else if (req_valid) begin
         m_pend <= 1'b1;
         m_op   <= req_op;
         m_d    <= int'(req_data);
      end
   end

   always @(negedge clk) begin : compare
      if (run_cmp) begin
         check("req_ready", 32'(req_ready), 32'(!(m_pend || m_resp)));
         check("rsp_valid", 32'(rsp_valid), 32'(m_resp));
         check("reg_a", 32'(reg_a), 32'(m_a % 256));
         check("reg_b", 32'(reg_b), 32'(m_b % 256));
         check("swap_count", 32'(swap_count), 32'(m_swaps % 256));
         if (m_resp) begin
            check("rsp_a", 32'(rsp_a), 32'(m_ra % 256));
            check("rsp_b", 32'(rsp_b), 32'(m_rb % 256));
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic do_reset();
      rst_n     = 1'b0;
      req_valid = 1'b0;
      rsp_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Issue one command, optionally stall the response for 'stall' cycles while presenting a SWAP.
   task automatic do_cmd(input logic [1:0] op, input logic [7:0] d, input int stall,
                         output logic [7:0] ra, output logic [7:0] rb, output int lat);
      int n;
      n = 0;
      while ((m_pend || m_resp) && n < 20) begin @(negedge clk); n++; end
      req_valid = 1'b1;
      req_op    = op;
      req_data  = d;
      @(negedge clk);
      req_valid = (stall > 0);
      req_op    = 2'b11;
      req_data  = 8'($urandom);
      lat = 1;
      n   = 0;
      while (!rsp_valid && n < 20) begin @(negedge clk); lat++; n++; end
      if (n >= 20) check("rsp_timeout", 32'(rsp_valid), 32'd1);
      ra = rsp_a;
      rb = rsp_b;
      repeat (stall) @(negedge clk);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      req_valid = 1'b0;
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      logic [7:0] ra, rb;
      int         lat;

      do_reset();
      run_cmp = 1'b1;
      check("reset_req_ready", 32'(req_ready), 32'd1);
      check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      check("reset_rsp_a", 32'(rsp_a), 32'd0);
      check("reset_rsp_b", 32'(rsp_b), 32'd0);
      check("reset_reg_a", 32'(reg_a), 32'd5);
      check("reset_reg_b", 32'(reg_b), 32'd10);
      check("reset_swap_count", 32'(swap_count), 32'd0);

      do_cmd(2'b00, 8'h77, 0, ra, rb, lat);
      check("read_rsp_a", 32'(ra), 32'd5);
      check("read_rsp_b", 32'(rb), 32'd10);
      check("read_latency", 32'(lat), 32'd2);
      check("read_swap_count", 32'(swap_count), 32'd0);

      do_cmd(2'b11, 8'h00, 0, ra, rb, lat);
      check("swap1_rsp_a", 32'(ra), 32'd10);
      check("swap1_rsp_b", 32'(rb), 32'd5);
      check("swap1_count", 32'(swap_count), 32'd1);
      do_cmd(2'b11, 8'h00, 0, ra, rb, lat);
      check("swap2_rsp_a", 32'(ra), 32'd5);
      check("swap2_rsp_b", 32'(rb), 32'd10);
      check("swap2_count", 32'(swap_count), 32'd2);

      do_cmd(2'b01, 8'h3C, 0, ra, rb, lat);
      check("loada_rsp_a", 32'(ra), 32'h3C);
      check("loada_rsp_b", 32'(rb), 32'd10);
      do_cmd(2'b11, 8'h00, 0, ra, rb, lat);
      check("swap3_rsp_a", 32'(ra), 32'd10);
      check("swap3_rsp_b", 32'(rb), 32'h3C);

      // Stalled response with a SWAP held on the request side; the model rejects early acceptance.
      do_cmd(2'b11, 8'h00, 4, ra, rb, lat);
      check("stall_rsp_a", 32'(ra), 32'h3C);
      check("stall_rsp_b", 32'(rb), 32'd10);
      check("stall_count", 32'(swap_count), 32'd4);

      // Reset while LOAD_B is in EXEC: the command must vanish.
      @(negedge clk);
      req_valid = 1'b1;
      req_op    = 2'b10;
      req_data  = 8'hFF;
      @(negedge clk);
      req_valid = 1'b0;
      rst_n     = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check("rstexec_rsp_valid", 32'(rsp_valid), 32'd0);
         @(negedge clk);
      end
      check("rstexec_reg_a", 32'(reg_a), 32'd5);
      check("rstexec_reg_b", 32'(reg_b), 32'd10);
      check("rstexec_count", 32'(swap_count), 32'd0);

      for (int i = 0; i < 256; i++) do_cmd(2'b11, 8'h00, 0, ra, rb, lat);
      check("wrap_count", 32'(swap_count), 32'd0);
      check("wrap_reg_a", 32'(reg_a), 32'd5);
      check("wrap_reg_b", 32'(reg_b), 32'd10);

      for (int i = 0; i < 300; i++) begin
         repeat ($urandom_range(0, 2)) @(negedge clk);
         do_cmd(2'($urandom), 8'($urandom), int'($urandom_range(0, 3)), ra, rb, lat);
         check("rand_latency", 32'(lat), 32'd2);
      end

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/reg_exchange_responder.md
# reg_exchange_responder

Responder side of the register-exchange request/response interface. It owns two WIDTH-bit registers A and B and executes load, read and swap commands from an initiator over a valid/ready handshake. SWAP updates both registers on the same clock edge, so each register takes the other's pre-edge value and neither sees a value written earlier in the same edge. Results return on a separate valid/ready response channel, which lets the initiator check post-operation values without sampling races.

## Interface
- WIDTH, 8, data width of registers A/B and of req_data
- A_INIT, 5, value of register A after reset
- B_INIT, 10, value of register B after reset
- clk  input  1  single clock; all state changes on posedge
- rst_n  input  1  reset, synchronous, active-low
- req_valid  input  1  initiator presents a command
- req_ready  output  1  responder can accept a command
- req_op  input  2  00 READ, 01 LOAD_A, 10 LOAD_B, 11 SWAP
- req_data  input  WIDTH  load value; ignored for READ and SWAP
- rsp_valid  output  1  response available
- rsp_ready  input  1  initiator accepts the response
- rsp_a  output  WIDTH  value of A after the operation
- rsp_b  output  WIDTH  value of B after the operation
- reg_a  output  WIDTH  live value of register A
- reg_b  output  WIDTH  live value of register B
- swap_count  output  8  number of completed SWAPs, modulo 256

## Operation
- FSM has three states: IDLE, EXEC, RESP. Reset state is IDLE.
- IDLE:
  - req_ready=1.
  - If req_valid=1 at a posedge, the command is accepted: op and data are captured and the FSM moves to EXEC.
  - Otherwise the FSM stays in IDLE.
- EXEC:
  - req_ready=0.
  - At the next posedge the operation is applied and the FSM moves to RESP.
  - READ: no register change.
  - LOAD_A: A ← data.
  - LOAD_B: B ← data.
  - SWAP: A ← old B and B ← old A, on the same edge. swap_count increments on this edge.
- RESP:
  - rsp_valid=1.
  - rsp_a and rsp_b hold the post-operation A/B values and stay stable while rsp_ready=0.
  - If rsp_ready=1 at a posedge, the FSM moves to IDLE.
- req_ready is high only in IDLE. A new command is never accepted while a response is pending, so there is one outstanding transaction at most.
- Captured data is truncated to WIDTH; no sign handling.
- swap_count wraps from 255 to 0 with no flag.
- Reset asserted in any state:
  - The FSM returns to IDLE.
  - A=A_INIT, B=B_INIT, swap_count=0.
  - rsp_valid=0 and rsp_a/rsp_b are 0.
  - Any in-flight command is dropped and produces no response.
- req_valid, req_op and req_data are don't-care outside IDLE.
- The initiator may drop req_valid at any time while req_ready=0 without effect.

## Timing
- Reset values: req_ready=1, rsp_valid=0, rsp_a=0, rsp_b=0, reg_a=A_INIT, reg_b=B_INIT, swap_count=0.
- Command accepted at edge N:
  - Registers and swap_count update at edge N+1.
  - rsp_valid rises after edge N+1.
- Command-to-response latency is 2 cycles.
- With rsp_ready held high:
  - Response handshake completes at edge N+2.
  - req_ready is high again after edge N+2.
  - The next command can be accepted at edge N+3, so the minimum period is 3 cycles per command.
- reg_a and reg_b change only at the EXEC→RESP edge or on reset.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset, then READ → rsp_a=5, rsp_b=10, swap_count=0; rsp_valid is seen exactly 2 cycles after acceptance.
- SWAP from reset values → rsp_a=10, rsp_b=5, swap_count=1; a second SWAP → rsp_a=5, rsp_b=10, swap_count=2.
- LOAD_A with data 0x3C, then SWAP → first response is 0x3C/10, second response is 10/0x3C; reg_a and reg_b change only on the EXEC→RESP edges.
- Hold rsp_ready=0 for 4 cycles in RESP while req_valid=1 with op SWAP:
  - rsp_valid, rsp_a and rsp_b are stable and req_ready=0 throughout.
  - No second command is accepted until the cycle after the response handshake.
- 256 back-to-back SWAPs → swap_count wraps to 0; final A=5, B=10.
- Issue LOAD_B with 0xFF and assert rst_n=0 during EXEC → after reset, A=5, B=10, rsp_valid never rises, swap_count=0.
